seq_top: RTL and testbench
==========================

// Module: seq_top
// PURPOSE
//  Self-running sequencer used as a top-level test design. After reset release it steps a
//  fixed program: initialise, count up, hold, adjust, pulse done, then halt.
//  All results appear on registered outputs a, b, c, d. There are no data inputs.
//  It sits at the top of the design, driven only by clock and reset.
// PARAMETERS
//  WIDTH        8  width of a, b, c
//  TARGET       5  value at which the count-up phase of a stops
//  HOLD_CYCLES  3  number of cycles spent in HOLD
//  C_STEP       3  amount added to c in ADJ
// PORTS
//  clk  in   1      single clock; all state updates on the rising edge
//  rst  in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  a    out  WIDTH  counter a, registered
//  b    out  WIDTH  phase flag: 1 during run, 0 after ADJ
//  c    out  WIDTH  accumulator c, registered
//  d    out  1      one-cycle done pulse
// BEHAVIOUR
//  - Reset (rst low, async): a=b=c=0, d=0, hold_cnt=0, state=INIT. Re-asserting reset
//    mid-program aborts it; after release the program restarts from INIT.
//  - Edge n = nth rising clk edge after rst goes high. One state executes per edge.
//  - INIT (edge 1): a<=1, b<=1, c<=1, d<=0; go to UP.
//  - UP: a<=a+1, c<=c+1 each edge. When a==TARGET-1 (so a becomes TARGET), go to HOLD
//    with hold_cnt<=0. Default timing: edges 2..5, giving a=5, c=5 after edge 5.
//  - HOLD: outputs unchanged; hold_cnt<=hold_cnt+1. When hold_cnt==HOLD_CYCLES-1, go to ADJ.
//    Default timing: edges 6..8.
//  - ADJ (edge 9): a<=a-1, b<=0, c<=c+C_STEP; go to PULSE.
//  - PULSE (edge 10): d<=1; go to HALT.
//  - HALT (edge 11 onward): d<=0; a, b, c frozen. HALT is absorbing until the next reset.
//  - Arithmetic is modulo 2^WIDTH with no saturation. For the defaults, no overflow occurs.
//  - d is high for exactly one cycle, after edge 10. It is low at every other time,
//    including during reset.
//  - Outputs come directly from flops; there is no combinational path to the outputs.
//  - Unused state encodings go to HALT, with d<=0.
// STRUCTURE
//  - Shared package seq_top_pkg holds:
//      the state enum {INIT, UP, HOLD, ADJ, PULSE, HALT};
//      default constants for WIDTH, TARGET, HOLD_CYCLES, C_STEP.
//  - One sub-module is natural: seq_hold_timer, a counter with clear/enable and a
//    terminal-count output at HOLD_CYCLES-1, used by the HOLD state.
//  - Everything else (the FSM and the a/b/c/d registers) lives in seq_top.
// TESTING
//  - Hold rst low for 1 cycle, then release. After 7 edges: a=5, b=1, c=5, d=0.
//  - Same run, after 20 edges: a=4, b=0, c=8, d=0. Values stay stable for a further 99 cycles.
//  - Sample d every cycle: d=1 only after edge 10 and 0 everywhere else (exactly one pulse).
//  - Assert rst low asynchronously mid-UP (after edge 3, between clock edges):
//      outputs go to 0 immediately, without waiting for a clock edge;
//      after release, edge-7 values are a=5, b=1, c=5 again.
//  - While rst is held low for 5 cycles: a=b=c=0, d=0 throughout.
//  - Parameter run TARGET=3, HOLD_CYCLES=1, C_STEP=2, with a and c checked after each edge:
//      UP ends at edge 3 with a=3;
//      ADJ at edge 5 gives a=2, b=0, c=5;
//      d pulses after edge 6.

Source files
------------

// File: rtl/seq_top_pkg.sv
// rtl/seq_top_pkg.sv - shared state encoding and default constants for the sequencer
package seq_top_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_UP    = 3'd1,
    S_HOLD  = 3'd2,
    S_ADJ   = 3'd3,
    S_PULSE = 3'd4,
    S_HALT  = 3'd5
  } seq_state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TARGET      = 5;
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_C_STEP      = 3;

endpackage

// File: rtl/seq_hold_timer.sv
// rtl/seq_hold_timer.sv - hold-phase cycle counter with clear/enable and terminal count
module seq_hold_timer
  import seq_top_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (clr) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign tc = (hold_cnt == TC_VAL);

endmodule

// File: rtl/seq_top.sv
// rtl/seq_top.sv - self-running sequencer: init, count up, hold, adjust, pulse done, halt
module seq_top
  import seq_top_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TARGET      = DEF_TARGET,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int C_STEP      = DEF_C_STEP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             d
);

  localparam logic [WIDTH-1:0] UP_LAST = WIDTH'(TARGET - 1);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(C_STEP);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  seq_state_t state;
  logic       hold_tc;
  logic       hold_clr;
  logic       hold_en;

  // Timer is held cleared outside HOLD so every HOLD entry starts from zero.
  assign hold_clr = (state != S_HOLD);
  assign hold_en  = (state == S_HOLD);

  seq_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk(clk),
    .rst(rst),
    .clr(hold_clr),
    .en (hold_en),
    .tc (hold_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          a     <= ONE;
          b     <= ONE;
          c     <= ONE;
          d     <= 1'b0;
          state <= S_UP;
        end
        S_UP: begin
          a <= a + ONE;
          c <= c + ONE;
          if (a == UP_LAST) state <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_tc) state <= S_ADJ;
        end
        S_ADJ: begin
          a     <= a - ONE;
          b     <= '0;
          c     <= c + STEP;
          state <= S_PULSE;
        end
        S_PULSE: begin
          d     <= 1'b1;
          state <= S_HALT;
        end
        S_HALT: begin
          d <= 1'b0;
        end
        default: begin
          d     <= 1'b0;
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_top.sv
// tb/tb_seq_top.sv - directed self-checking bench for seq_top (default and reduced parameter sets)
module tb_seq_top;

  logic       clk;
  logic       rst;
  logic       rst_p;
  logic [7:0] a, b, c;
  logic       d;
  logic [7:0] pa, pb, pc;
  logic       pd;

  int checks;
  int errors;

  seq_top u_dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d)
  );

  seq_top #(
    .WIDTH      (8),
    .TARGET     (3),
    .HOLD_CYCLES(1),
    .C_STEP     (2)
  ) u_dut_p (
    .clk(clk),
    .rst(rst_p),
    .a  (pa),
    .b  (pb),
    .c  (pc),
    .d  (pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-computed a/c per edge for TARGET=3, HOLD_CYCLES=1, C_STEP=2 (edges 1..8).
  logic [7:0] pa_exp [8] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2};
  logic [7:0] pc_exp [8] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd5, 8'd5, 8'd5, 8'd5};

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    rst_p  = 1'b0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", {a, b, c, 7'd0, d}, 32'h0);
    end

    // Main program run, d sampled every cycle
    rst = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("d_edge%0d", n), {31'd0, d}, {31'd0, (n == 10)});
      if (n == 5)  chk("edge5_ac",   {a, c}, {8'd5, 8'd5});
      if (n == 7)  chk("edge7",      {a, b, c, 7'd0, d}, {8'd5, 8'd1, 8'd5, 8'd0});
      if (n == 9)  chk("edge9_adj",  {a, b, c}, {8'd4, 8'd0, 8'd8});
      if (n == 20) chk("edge20",     {a, b, c, 7'd0, d}, {8'd4, 8'd0, 8'd8, 8'd0});
    end
    for (int i = 0; i < 99; i++) begin
      step();
      chk("halt_stable", {a, b, c, 7'd0, d}, {8'd4, 8'd0, 8'd8, 8'd0});
    end

    // Asynchronous abort mid-UP
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 3; n++) step();
    chk("pre_abort_a", {24'd0, a}, 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {a, b, c, 7'd0, d}, 32'h0);
    @(negedge clk);
    chk("async_rst_hold", {a, b, c, 7'd0, d}, 32'h0);
    rst = 1'b1;
    for (int n = 1; n <= 7; n++) step();
    chk("restart_edge7", {a, b, c, 7'd0, d}, {8'd5, 8'd1, 8'd5, 8'd0});

    // Reduced parameter set
    rst_p = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk($sformatf("p_a_edge%0d", n), {24'd0, pa}, {24'd0, pa_exp[n-1]});
      chk($sformatf("p_c_edge%0d", n), {24'd0, pc}, {24'd0, pc_exp[n-1]});
      chk($sformatf("p_d_edge%0d", n), {31'd0, pd}, {31'd0, (n == 6)});
      if (n == 3) chk("p_b_edge3", {24'd0, pb}, 32'd1);
      if (n == 5) chk("p_b_edge5", {24'd0, pb}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
